// File: rtl/spiio_fifo.sv
// spiio_fifo: byte-oriented SPI master with TX/RX FIFOs, CPOL/CPHA/LSB-first
// modes, programmable SCK divider, software slave selects, general outputs and
// an end-of-burst interrupt. Eight-byte register window, one clock domain.
//
// Bus handshake: cs marks one access per clk cycle in which it is high; rw
// selects read (1) or write (0). Writes land on the clk edge that ends the
// strobe. Read data on DO is combinational. A DATA read pops the RX FIFO on
// that same edge.
module spiio_fifo #(
  parameter int          NUM_SS     = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter int          POUT_WIDTH = 2,
  parameter logic [7:0]  DIV_RESET  = 8'd5
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  cs,
  input  logic                  rw,
  input  logic [2:0]            AD,
  input  logic [7:0]            DI,
  output logic [7:0]            DO,
  output logic                  irq,
  output logic                  msck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     mss,
  output logic [POUT_WIDTH-1:0] pout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  // Control/status registers
  logic [3:0]            ctrl_q;   // {LSBFIRST, IRQEN, CPHA, CPOL}
  logic [7:0]            div_q;
  logic [NUM_SS-1:0]     ss_q;
  logic [POUT_WIDTH-1:0] pout_q;
  logic                  irq_q, irq_d;
  logic                  txovf_q, txovf_d;
  logic                  rxovr_q, rxovr_d;

  // FIFOs: pointers carry one extra wrap bit so full and empty differ
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0]    tx_head;

  // Shift engine
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] edge_q, edge_d;      // msck edges already produced in this byte
  logic       msck_q, msck_d;
  logic       mosi_q, mosi_d;
  logic [7:0] txsh_q, txsh_d;
  logic [7:0] rxsh_q, rxsh_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       lsb_q, lsb_d;
  logic [7:0] divl_q, divl_d;

  // Access strobes and FIFO events
  logic wr_en, rd_en;
  logic tx_push_req, tx_push, tx_pop;
  logic rx_push_req, rx_push, rx_pop;
  logic sample_edge;

  assign wr_en = cs & ~rw;
  assign rd_en = cs & rw;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];

  // Shift FSM next state; a byte is loaded from the TX head only in IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    msck_d      = msck_q;
    mosi_d      = mosi_q;
    txsh_d      = txsh_q;
    rxsh_d      = rxsh_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    divl_d      = divl_q;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    sample_edge = 1'b0;
    case (state_q)
      ST_IDLE: begin
        msck_d = ctrl_q[0];
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          state_d = ST_SHIFT;
          cpol_d  = ctrl_q[0];
          cpha_d  = ctrl_q[1];
          lsb_d   = ctrl_q[3];
          divl_d  = div_q;
          cnt_d   = 8'd0;
          edge_d  = 5'd0;
          if (!ctrl_q[1]) begin
            // Leading-edge sampling needs the first bit on mosi right away
            mosi_d = ctrl_q[3] ? tx_head[0] : tx_head[7];
            txsh_d = ctrl_q[3] ? (tx_head >> 1) : (tx_head << 1);
          end else begin
            txsh_d = tx_head;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q == divl_q) begin
          cnt_d  = 8'd0;
          msck_d = ~msck_q;
          edge_d = edge_q + 5'd1;
          // edge number is edge_q+1: odd when edge_q is even
          sample_edge = (~edge_q[0]) ^ cpha_q;
          if (sample_edge) begin
            rxsh_d = lsb_q ? {miso, rxsh_q[7:1]} : {rxsh_q[6:0], miso};
          end else if (edge_q != 5'd15) begin
            mosi_d = lsb_q ? txsh_q[0] : txsh_q[7];
            txsh_d = lsb_q ? (txsh_q >> 1) : (txsh_q << 1);
          end
          if (edge_q == 5'd15) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        rx_push_req = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO admission and sticky flags; a same-cycle pop frees room for a push
  always_comb begin
    tx_push_req = wr_en && (AD == 3'd0);
    tx_push     = tx_push_req && (!tx_full || tx_pop);
    rx_pop      = rd_en && (AD == 3'd0) && !rx_empty;
    rx_push     = rx_push_req && (!rx_full || rx_pop);
    irq_d   = (rx_push_req && tx_empty) ||
              (irq_q && !(wr_en && (AD == 3'd1) && DI[7]));
    txovf_d = (tx_push_req && tx_full && !tx_pop) ||
              (txovf_q && !(wr_en && (AD == 3'd1) && DI[6]));
    rxovr_d = (rx_push_req && rx_full && !rx_pop) ||
              (rxovr_q && !(wr_en && (AD == 3'd1) && DI[5]));
  end

  // State, pointers, flags and configuration registers
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      edge_q  <= 5'd0;
      msck_q  <= 1'b0;
      mosi_q  <= 1'b1;
      txsh_q  <= 8'd0;
      rxsh_q  <= 8'd0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      divl_q  <= 8'd0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      irq_q   <= 1'b0;
      txovf_q <= 1'b0;
      rxovr_q <= 1'b0;
      ctrl_q  <= 4'd0;
      div_q   <= DIV_RESET;
      ss_q    <= '0;
      pout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      msck_q  <= msck_d;
      mosi_q  <= mosi_d;
      txsh_q  <= txsh_d;
      rxsh_q  <= rxsh_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      divl_q  <= divl_d;
      irq_q   <= irq_d;
      txovf_q <= txovf_d;
      rxovr_q <= rxovr_d;
      if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + PW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + PW'(1);
      if (wr_en) begin
        case (AD)
          3'd2: ctrl_q <= DI[3:0];
          3'd3: div_q  <= DI;
          3'd4: ss_q   <= DI[NUM_SS-1:0];
          3'd5: pout_q <= DI[POUT_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= DI;
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rxsh_q;
  end

  // Read mux
  always_comb begin
    logic [7:0] ss_rd;
    logic [7:0] pout_rd;
    ss_rd   = 8'h00;
    pout_rd = 8'h00;
    ss_rd[NUM_SS-1:0]       = ss_q;
    pout_rd[POUT_WIDTH-1:0] = pout_q;
    DO = 8'h00;
    case (AD)
      3'd0: DO = rx_empty ? 8'hFF : rx_mem[rx_rp_q[AW-1:0]];
      3'd1: DO = {irq_q, txovf_q, rxovr_q, rx_empty, rx_full, tx_empty, tx_full,
                  !((state_q == ST_IDLE) && tx_empty)};
      3'd2: DO = {4'h0, ctrl_q};
      3'd3: DO = div_q;
      3'd4: DO = ss_rd;
      3'd5: DO = pout_rd;
      default: DO = 8'h00;
    endcase
  end

  assign irq  = irq_q & ctrl_q[2];
  assign msck = msck_q;
  assign mosi = mosi_q;
  assign mss  = ~ss_q;
  assign pout = pout_q;

endmodule

// File: tb/tb_spiio_fifo.sv
// Bench for spiio_fifo: register vector table, then directed SPI sequences
// (loopback, all modes against a slave model, FIFO overflow, irq, reset).
module tb_spiio_fifo;

  logic       clk = 1'b0;
  logic       RESET;
  logic       cs, rw;
  logic [2:0] AD;
  logic [7:0] DI, DO;
  logic       irq, msck, mosi, miso;
  logic [1:0] mss, pout;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Slave model / loopback selection
  logic       loop_en = 1'b0;
  logic       slv_en  = 1'b0;
  logic       slv_cpha = 1'b0;
  logic       slv_lsb  = 1'b0;
  logic [7:0] slv_byte = 8'h00;
  logic [7:0] cap;
  logic       slv_miso = 1'b1;
  int         slv_edges = 0;
  logic       prev_en = 1'b0;
  logic       prev_msck = 1'b0;

  // msck edge timestamps
  logic rec_en = 1'b0;
  int   edge_t[$];

  assign miso = loop_en ? mosi : slv_miso;

  spiio_fifo #(.NUM_SS(2), .FIFO_DEPTH(4), .POUT_WIDTH(2), .DIV_RESET(8'd5)) dut (
    .clk(clk), .RESET(RESET), .cs(cs), .rw(rw), .AD(AD), .DI(DI), .DO(DO),
    .irq(irq), .msck(msck), .mosi(mosi), .miso(miso), .mss(mss), .pout(pout)
  );

  // clock / cycle counter (counted on the inactive edge so stamps are stable)
  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  always @(msck) if (rec_en) edge_t.push_back(cyc);

  // Slave: samples mosi on sample edges, drives next miso bit on shift edges
  always @(msck, slv_en) begin
    int idx;
    if (slv_en && !prev_en) begin
      slv_edges = 0;
      cap       = 8'h00;
      slv_miso  = slv_cpha ? 1'b1 : slv_byte[slv_lsb ? 0 : 7];
    end else if (slv_en && (msck !== prev_msck)) begin
      slv_edges++;
      if (((slv_edges % 2) == 1) != slv_cpha) begin
        cap = slv_lsb ? {mosi, cap[7:1]} : {cap[6:0], mosi};
      end else begin
        idx = slv_cpha ? (slv_edges - 1) / 2 : slv_edges / 2;
        if (idx < 8) slv_miso = slv_byte[slv_lsb ? idx : 7 - idx];
      end
    end
    prev_en   = slv_en;
    prev_msck = msck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: called at a negedge, return at the next negedge
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1 d = DO;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic [7:0] s;
    s = 8'h01;
    for (int i = 0; i < 400 && s[0]; i++) rd(3'd1, s);
    chk({name, "_busy"}, {31'd0, s[0]}, 32'd0);
  endtask

  typedef struct {
    logic       rw;
    logic [2:0] ad;
    logic [7:0] di;
    logic [7:0] exp_do;
    logic [1:0] exp_mss;
    logic [1:0] exp_pout;
  } vec_t;

  vec_t vt[24];

  initial begin
    logic [7:0] d;
    int base, bad;
    logic cpol_m, cpha_m, lsb_m;

    vt[0]  = '{1'b1, 3'd1, 8'h00, 8'h14, 2'b11, 2'b00};
    vt[1]  = '{1'b1, 3'd2, 8'h00, 8'h00, 2'b11, 2'b00};
    vt[2]  = '{1'b1, 3'd3, 8'h00, 8'h05, 2'b11, 2'b00};
    vt[3]  = '{1'b1, 3'd4, 8'h00, 8'h00, 2'b11, 2'b00};
    vt[4]  = '{1'b1, 3'd5, 8'h00, 8'h00, 2'b11, 2'b00};
    vt[5]  = '{1'b1, 3'd6, 8'h00, 8'h00, 2'b11, 2'b00};
    vt[6]  = '{1'b1, 3'd7, 8'h00, 8'h00, 2'b11, 2'b00};
    vt[7]  = '{1'b1, 3'd0, 8'h00, 8'hFF, 2'b11, 2'b00};
    vt[8]  = '{1'b0, 3'd5, 8'h02, 8'h00, 2'b11, 2'b10};
    vt[9]  = '{1'b1, 3'd5, 8'h00, 8'h02, 2'b11, 2'b10};
    vt[10] = '{1'b0, 3'd4, 8'h01, 8'h00, 2'b10, 2'b10};
    vt[11] = '{1'b1, 3'd4, 8'h00, 8'h01, 2'b10, 2'b10};
    vt[12] = '{1'b0, 3'd2, 8'h0F, 8'h00, 2'b10, 2'b10};
    vt[13] = '{1'b1, 3'd2, 8'h00, 8'h0F, 2'b10, 2'b10};
    vt[14] = '{1'b0, 3'd2, 8'h00, 8'h00, 2'b10, 2'b10};
    vt[15] = '{1'b0, 3'd3, 8'hA7, 8'h00, 2'b10, 2'b10};
    vt[16] = '{1'b1, 3'd3, 8'h00, 8'hA7, 2'b10, 2'b10};
    vt[17] = '{1'b0, 3'd3, 8'h05, 8'h00, 2'b10, 2'b10};
    vt[18] = '{1'b0, 3'd6, 8'hFF, 8'h00, 2'b10, 2'b10};
    vt[19] = '{1'b1, 3'd6, 8'h00, 8'h00, 2'b10, 2'b10};
    vt[20] = '{1'b0, 3'd1, 8'hE0, 8'h00, 2'b10, 2'b10};
    vt[21] = '{1'b1, 3'd1, 8'h00, 8'h14, 2'b10, 2'b10};
    vt[22] = '{1'b0, 3'd4, 8'h00, 8'h00, 2'b11, 2'b10};
    vt[23] = '{1'b0, 3'd5, 8'h00, 8'h00, 2'b11, 2'b00};

    // reset
    RESET = 1'b0; cs = 1'b0; rw = 1'b0; AD = 3'd0; DI = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_msck", {31'd0, msck}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd1);
    chk("rst_mss",  {30'd0, mss}, 32'd3);
    chk("rst_pout", {30'd0, pout}, 32'd0);
    chk("rst_irq",  {31'd0, irq}, 32'd0);
    RESET = 1'b1;
    @(negedge clk);

    // register vector table
    for (int i = 0; i < 24; i++) begin
      if (vt[i].rw) begin
        rd(vt[i].ad, d);
        chk($sformatf("vec%0d_do", i), {24'd0, d}, {24'd0, vt[i].exp_do});
      end else begin
        wr(vt[i].ad, vt[i].di);
      end
      chk($sformatf("vec%0d_mss", i), {30'd0, mss}, {30'd0, vt[i].exp_mss});
      chk($sformatf("vec%0d_pout", i), {30'd0, pout}, {30'd0, vt[i].exp_pout});
    end

    // 1: mode 0, DIV=0, loopback A5
    wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd4, 8'h01); wr(3'd1, 8'hE0);
    loop_en = 1'b1;
    repeat (2) @(negedge clk);
    base = edge_t.size(); rec_en = 1'b1;
    wr(3'd0, 8'hA5);
    wait_idle("t1");
    rec_en = 1'b0;
    chk("t1_edges", edge_t.size() - base, 16);
    bad = 0;
    for (int i = 1; i < 16 && base + i < edge_t.size(); i++)
      if (edge_t[base+i] - edge_t[base+i-1] != 1) bad++;
    chk("t1_spacing", bad, 0);
    rd(3'd0, d); chk("t1_rx", {24'd0, d}, 32'hA5);
    chk("t1_mss", {30'd0, mss}, 32'd2);
    rd(3'd1, d); chk("t1_stat", {24'd0, d}, 32'h94);

    // 2: modes 0-3 LSB first, plus mode 0 MSB first, slave returns 3C
    loop_en = 1'b0;
    wr(3'd3, 8'h01);
    for (int m = 0; m < 5; m++) begin
      cpol_m = (m < 4) ? m[0] : 1'b0;
      cpha_m = (m < 4) ? m[1] : 1'b0;
      lsb_m  = (m < 4);
      wr(3'd2, {4'h0, lsb_m, 1'b0, cpha_m, cpol_m});
      repeat (3) @(negedge clk);
      chk($sformatf("t2_m%0d_idle_msck", m), {31'd0, msck}, {31'd0, cpol_m});
      slv_cpha = cpha_m; slv_lsb = lsb_m; slv_byte = 8'h3C;
      slv_en = 1'b1;
      wr(3'd0, 8'hC5);
      wait_idle($sformatf("t2_m%0d", m));
      slv_en = 1'b0;
      chk($sformatf("t2_m%0d_edges", m), slv_edges, 16);
      chk($sformatf("t2_m%0d_mosi", m), {24'd0, cap}, 32'hC5);
      rd(3'd0, d); chk($sformatf("t2_m%0d_rx", m), {24'd0, d}, 32'h3C);
      chk($sformatf("t2_m%0d_end_msck", m), {31'd0, msck}, {31'd0, cpol_m});
    end

    // 3/4: six back-to-back writes; first is already in the shifter when the
    // second lands, so four more fit and the sixth is dropped. Five bytes go
    // out, RX keeps the first four and drops the fifth.
    wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd1, 8'hE0);
    loop_en = 1'b1;
    repeat (2) @(negedge clk);
    base = edge_t.size(); rec_en = 1'b1;
    wr(3'd0, 8'h11); wr(3'd0, 8'h22); wr(3'd0, 8'h33);
    wr(3'd0, 8'h44); wr(3'd0, 8'h55); wr(3'd0, 8'h66);
    wait_idle("t3");
    rec_en = 1'b0;
    chk("t3_edges", edge_t.size() - base, 80);
    bad = 0;
    for (int i = 1; i < 80 && base + i < edge_t.size(); i++)
      if (edge_t[base+i] - edge_t[base+i-1] != ((i % 16 == 0) ? 3 : 1)) bad++;
    chk("t3_gap", bad, 0);
    rd(3'd1, d); chk("t3_stat", {24'd0, d}, 32'hEC);
    rd(3'd0, d); chk("t4_rx0", {24'd0, d}, 32'h11);
    rd(3'd0, d); chk("t4_rx1", {24'd0, d}, 32'h22);
    rd(3'd0, d); chk("t4_rx2", {24'd0, d}, 32'h33);
    rd(3'd0, d); chk("t4_rx3", {24'd0, d}, 32'h44);
    rd(3'd0, d); chk("t4_rx_empty", {24'd0, d}, 32'hFF);
    rd(3'd1, d); chk("t4_stat", {24'd0, d}, 32'hF4);

    // 5: irq only at end of a two-byte burst, cleared by STAT write
    wr(3'd1, 8'hE0); wr(3'd2, 8'h04);
    repeat (2) @(negedge clk);
    chk("t5_irq_pre", {31'd0, irq}, 32'd0);
    base = edge_t.size(); rec_en = 1'b1;
    wr(3'd0, 8'h5A); wr(3'd0, 8'hC3);
    for (int i = 0; i < 200 && !irq; i++) @(negedge clk);
    rec_en = 1'b0;
    chk("t5_irq_set", {31'd0, irq}, 32'd1);
    chk("t5_irq_edges", edge_t.size() - base, 32);
    rd(3'd0, d); chk("t5_rx0", {24'd0, d}, 32'h5A);
    rd(3'd0, d); chk("t5_rx1", {24'd0, d}, 32'hC3);
    wr(3'd1, 8'h80);
    chk("t5_irq_clr", {31'd0, irq}, 32'd0);
    rd(3'd1, d); chk("t5_stat", {24'd0, d}, 32'h14);

    // 6: reset in the middle of a byte
    wr(3'd2, 8'h01); wr(3'd3, 8'h03); wr(3'd4, 8'h01); wr(3'd5, 8'h03);
    wr(3'd0, 8'h96); wr(3'd0, 8'h69);
    repeat (20) @(negedge clk);
    #2 RESET = 1'b0;
    #1;
    chk("t6_msck", {31'd0, msck}, 32'd0);
    chk("t6_mosi", {31'd0, mosi}, 32'd1);
    chk("t6_mss",  {30'd0, mss}, 32'd3);
    chk("t6_pout", {30'd0, pout}, 32'd0);
    @(negedge clk);
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    rd(3'd1, d); chk("t6_stat", {24'd0, d}, 32'h14);
    rd(3'd0, d); chk("t6_rx", {24'd0, d}, 32'hFF);
    rd(3'd2, d); chk("t6_ctrl", {24'd0, d}, 32'h00);
    rd(3'd3, d); chk("t6_div", {24'd0, d}, 32'h05);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
